// File: rtl/timebase_scheduler_if.sv
// Configuration write port of the timebase scheduler: a valid/ready
// handshake carrying channel index, period, mode and enable.
`timescale 1ns/1ps
interface timebase_scheduler_if #(
    parameter int N_CH     = 4,
    parameter int PERIOD_W = 16
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                cfg_valid;
    logic                cfg_ready;
    logic [CH_W-1:0]     cfg_ch;
    logic [PERIOD_W-1:0] cfg_period;
    logic                cfg_mode;
    logic                cfg_enable;

    // Requester side: drives the write, watches ready.
    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_period,
        output cfg_mode,
        output cfg_enable,
        input  cfg_ready
    );

    // Scheduler side: accepts the write, drives ready.
    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_period,
        input  cfg_mode,
        input  cfg_enable,
        output cfg_ready
    );
endinterface

// File: rtl/timebase_scheduler.sv
// Shared 100 Hz timebase: one prescaler producing a 10 ms tick, plus
// N_CH software timers serviced one channel per cycle by a single
// decrementer sweep that starts on every tick.
`timescale 1ns/1ps
module timebase_scheduler #(
    parameter int CLK_DIV  = 500000,
    parameter int N_CH     = 4,
    parameter int PERIOD_W = 16,
    localparam int PS_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  CLK_50_MHz,
    input  logic                  reset,
    timebase_scheduler_if.slave   cfg,
    output logic                  tick_100hz,
    output logic [N_CH-1:0]       ch_fire,
    output logic [N_CH-1:0]       ch_busy,
    output logic [PS_W-1:0]       prescale
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } state_t;

    // Prescaler
    logic [PS_W-1:0]     r_prescale;
    logic                r_tick;

    // Sweep FSM and registered outputs
    state_t              r_state;
    logic [CH_W-1:0]     r_idx;
    logic                r_cfg_ready;
    logic [N_CH-1:0]     r_ch_fire;

    // Per-channel timer state
    logic [PERIOD_W-1:0] r_cnt    [N_CH];
    logic [PERIOD_W-1:0] r_period [N_CH];
    logic [N_CH-1:0]     r_mode;
    logic [N_CH-1:0]     r_en;

    logic                w_ch_ok;
    logic                w_cfg_fire;

    // A channel index beyond N_CH-1 can only exist when N_CH is not a power
    // of two; such writes are dropped rather than aliased onto a real channel.
    generate
        if (N_CH == (1 << CH_W)) begin : g_ch_full
            assign w_ch_ok = 1'b1;
        end else begin : g_ch_part
            assign w_ch_ok = (cfg.cfg_ch < CH_W'(N_CH));
        end
    endgenerate

    assign w_cfg_fire = cfg.cfg_valid && r_cfg_ready && w_ch_ok;

    assign cfg.cfg_ready = r_cfg_ready;
    assign tick_100hz    = r_tick;
    assign ch_fire       = r_ch_fire;
    assign ch_busy       = r_en;
    assign prescale      = r_prescale;

    // Prescale counter 0..CLK_DIV-1; tick is registered so it is high in the
    // cycle where the counter reads 0 after a wrap, never straight out of reset.
    always_ff @(posedge CLK_50_MHz or posedge reset) begin
        if (reset) begin
            r_prescale <= '0;
            r_tick     <= 1'b0;
        end else if (r_prescale == PS_W'(CLK_DIV - 1)) begin
            r_prescale <= '0;
            r_tick     <= 1'b1;
        end else begin
            r_prescale <= r_prescale + PS_W'(1);
            r_tick     <= 1'b0;
        end
    end

    // Sweep FSM: accepts writes in IDLE, services one channel per cycle after
    // each tick. Writes and service never overlap, so the channel registers
    // have a single owner per cycle.
    always_ff @(posedge CLK_50_MHz or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_cfg_ready <= 1'b1;
            r_ch_fire   <= '0;
            r_mode      <= '0;
            r_en        <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i]    <= '0;
                r_period[i] <= '0;
            end
        end else begin
            r_ch_fire <= '0;
            case (r_state)
                ST_IDLE: begin
                    // A write in the tick cycle lands before the sweep starts,
                    // so the sweep already sees the new values.
                    if (w_cfg_fire) begin
                        r_period[cfg.cfg_ch] <= cfg.cfg_period;
                        r_cnt[cfg.cfg_ch]    <= cfg.cfg_period;
                        r_mode[cfg.cfg_ch]   <= cfg.cfg_mode;
                        r_en[cfg.cfg_ch]     <= cfg.cfg_enable &&
                                                (cfg.cfg_period != PERIOD_W'(0));
                    end
                    if (r_tick) begin
                        r_state     <= ST_SERVICE;
                        r_idx       <= '0;
                        r_cfg_ready <= 1'b0;
                    end else begin
                        r_state     <= ST_IDLE;
                        r_idx       <= '0;
                        r_cfg_ready <= 1'b1;
                    end
                end
                ST_SERVICE: begin
                    if (r_en[r_idx]) begin
                        if (r_cnt[r_idx] > PERIOD_W'(1)) begin
                            r_cnt[r_idx] <= r_cnt[r_idx] - PERIOD_W'(1);
                        end else if (r_cnt[r_idx] == PERIOD_W'(1)) begin
                            r_ch_fire[r_idx] <= 1'b1;
                            if (r_mode[r_idx]) begin
                                r_en[r_idx]  <= 1'b0;
                                r_cnt[r_idx] <= '0;
                            end else begin
                                r_cnt[r_idx] <= r_period[r_idx];
                            end
                        end else begin
                            // Enabled with a zero count cannot be reached
                            // through a write; hold rather than underflow.
                            r_cnt[r_idx] <= r_cnt[r_idx];
                        end
                    end else begin
                        r_cnt[r_idx] <= r_cnt[r_idx];
                    end
                    if (r_idx == CH_W'(N_CH - 1)) begin
                        r_state     <= ST_IDLE;
                        r_idx       <= '0;
                        r_cfg_ready <= 1'b1;
                    end else begin
                        r_state     <= ST_SERVICE;
                        r_idx       <= r_idx + CH_W'(1);
                        r_cfg_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_idx       <= '0;
                    r_cfg_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timebase_scheduler.sv
// Directed bench for timebase_scheduler with CLK_DIV=10, N_CH=4.
// Outputs are sampled 1 ns after each rising edge; T denotes the cycle
// in which tick_100hz is high.
`timescale 1ns/1ps
module tb_timebase_scheduler;

    localparam int CLK_DIV  = 10;
    localparam int N_CH     = 4;
    localparam int PERIOD_W = 16;
    localparam int PS_W     = $clog2(CLK_DIV);

    logic                CLK_50_MHz;
    logic                reset;
    logic                tick_100hz;
    logic [N_CH-1:0]     ch_fire;
    logic [N_CH-1:0]     ch_busy;
    logic [PS_W-1:0]     prescale;

    int n_cmp;
    int n_err;

    timebase_scheduler_if #(.N_CH(N_CH), .PERIOD_W(PERIOD_W)) cfg_if ();

    timebase_scheduler #(
        .CLK_DIV  (CLK_DIV),
        .N_CH     (N_CH),
        .PERIOD_W (PERIOD_W)
    ) dut (
        .CLK_50_MHz (CLK_50_MHz),
        .reset      (reset),
        .cfg        (cfg_if),
        .tick_100hz (tick_100hz),
        .ch_fire    (ch_fire),
        .ch_busy    (ch_busy),
        .prescale   (prescale)
    );

    initial CLK_50_MHz = 1'b0;
    always #10 CLK_50_MHz = ~CLK_50_MHz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK_50_MHz);
            #1;
        end
    endtask

    // Advance to the next tick cycle (bounded).
    task automatic wait_tick();
        int n;
        n = 0;
        step(1);
        while (tick_100hz !== 1'b1 && n < 12) begin
            step(1);
            n++;
        end
        chk("tick_wait", {31'd0, tick_100hz}, 32'd1);
    endtask

    // Issue one configuration write; returns one cycle after acceptance.
    task automatic write_cfg(input int ch, input int per, input logic mode, input logic en);
        int n;
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_ch     = 2'(ch);
        cfg_if.cfg_period = 16'(per);
        cfg_if.cfg_mode   = mode;
        cfg_if.cfg_enable = en;
        n = 0;
        while (cfg_if.cfg_ready !== 1'b1 && n < 10) begin
            step(1);
            n++;
        end
        chk("wr_ready_wait", {31'd0, cfg_if.cfg_ready}, 32'd1);
        step(1);
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_ch     = 2'd0;
        cfg_if.cfg_period = 16'd0;
        cfg_if.cfg_mode   = 1'b0;
        cfg_if.cfg_enable = 1'b0;

        // ---- Reset values ----
        #1;
        chk("rst_prescale", {28'd0, prescale}, 32'd0);
        chk("rst_tick",     {31'd0, tick_100hz}, 32'd0);
        chk("rst_fire",     {28'd0, ch_fire}, 32'd0);
        chk("rst_busy",     {28'd0, ch_busy}, 32'd0);
        chk("rst_ready",    {31'd0, cfg_if.cfg_ready}, 32'd1);
        step(2);
        reset = 1'b0;
        step(5);
        chk("pre_count5", {28'd0, prescale}, 32'd5);

        // Reset mid-count takes effect without a clock edge.
        reset = 1'b1;
        #1;
        chk("async_prescale", {28'd0, prescale}, 32'd0);
        chk("async_tick",     {31'd0, tick_100hz}, 32'd0);
        chk("async_ready",    {31'd0, cfg_if.cfg_ready}, 32'd1);
        #3;
        reset = 1'b0;
        step(9);
        chk("pre_9",        {28'd0, prescale}, 32'd9);
        chk("no_tick_yet",  {31'd0, tick_100hz}, 32'd0);
        step(1);
        chk("first_tick",   {31'd0, tick_100hz}, 32'd1);
        chk("tick_pre0",    {28'd0, prescale}, 32'd0);
        step(1);
        chk("tick_1wide",   {31'd0, tick_100hz}, 32'd0);
        step(9);
        chk("second_tick",  {31'd0, tick_100hz}, 32'd1);

        // ---- Periodic ch2, period 3 ----
        step(5);
        write_cfg(2, 3, 1'b0, 1'b1);
        chk("per_busy0", {28'd0, ch_busy}, 32'h4);
        for (int k = 1; k <= 9; k++) begin
            wait_tick();
            step(3);
            chk("per_t3", {28'd0, ch_fire}, 32'd0);
            step(1);
            chk("per_t4", {28'd0, ch_fire}, (k % 3 == 0) ? 32'h4 : 32'h0);
            step(1);
            chk("per_t5", {28'd0, ch_fire}, 32'd0);
            chk("per_busy", {28'd0, ch_busy}, 32'h4);
        end

        // ---- Rewrite running ch2 with enable=0 ----
        write_cfg(2, 3, 1'b0, 1'b0);
        chk("dis_busy", {28'd0, ch_busy}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            wait_tick();
            step(4);
            chk("dis_nofire", {28'd0, ch_fire}, 32'd0);
        end

        // ---- One-shot ch0, period 2 ----
        write_cfg(0, 2, 1'b1, 1'b1);
        chk("os_busy0", {28'd0, ch_busy}, 32'h1);
        wait_tick();
        step(2);
        chk("os_tick1_fire", {28'd0, ch_fire}, 32'd0);
        chk("os_tick1_busy", {28'd0, ch_busy}, 32'h1);
        wait_tick();
        step(1);
        chk("os_t1_busy", {28'd0, ch_busy}, 32'h1);
        step(1);
        chk("os_t2_fire", {28'd0, ch_fire}, 32'h1);
        chk("os_t2_busy", {28'd0, ch_busy}, 32'h0);
        step(1);
        chk("os_t3_fire", {28'd0, ch_fire}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            wait_tick();
            step(2);
            chk("os_after", {28'd0, ch_fire | ch_busy}, 32'd0);
        end

        // ---- Write during SERVICE (ch3, period 2) ----
        wait_tick();
        step(2);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_ch     = 2'd3;
        cfg_if.cfg_period = 16'd2;
        cfg_if.cfg_mode   = 1'b0;
        cfg_if.cfg_enable = 1'b1;
        chk("svc_ready_t2", {31'd0, cfg_if.cfg_ready}, 32'd0);
        step(1);
        chk("svc_ready_t3", {31'd0, cfg_if.cfg_ready}, 32'd0);
        step(1);
        chk("svc_ready_t4", {31'd0, cfg_if.cfg_ready}, 32'd0);
        step(1);
        chk("svc_ready_t5", {31'd0, cfg_if.cfg_ready}, 32'd1);
        step(1);
        cfg_if.cfg_valid = 1'b0;
        chk("svc_busy", {28'd0, ch_busy}, 32'h8);
        wait_tick();
        step(5);
        chk("svc_tick1", {28'd0, ch_fire}, 32'd0);
        wait_tick();
        step(5);
        chk("svc_tick2", {28'd0, ch_fire}, 32'h8);
        write_cfg(3, 2, 1'b0, 1'b0);

        // ---- Write and tick in the same cycle (ch1, period 1) ----
        wait_tick();
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_ch     = 2'd1;
        cfg_if.cfg_period = 16'd1;
        cfg_if.cfg_mode   = 1'b0;
        cfg_if.cfg_enable = 1'b1;
        chk("same_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);
        step(1);
        cfg_if.cfg_valid = 1'b0;
        chk("same_busy", {28'd0, ch_busy}, 32'h2);
        step(1);
        chk("same_t2", {28'd0, ch_fire}, 32'd0);
        step(1);
        chk("same_t3", {28'd0, ch_fire}, 32'h2);
        step(1);
        chk("same_t4", {28'd0, ch_fire}, 32'd0);
        wait_tick();
        step(3);
        chk("same_next", {28'd0, ch_fire}, 32'h2);

        // ---- Zero period with enable ----
        write_cfg(0, 0, 1'b0, 1'b1);
        chk("zero_busy", {28'd0, ch_busy}, 32'h2);
        wait_tick();
        step(2);
        chk("zero_nofire", {28'd0, ch_fire}, 32'd0);
        step(1);
        chk("zero_ch1", {28'd0, ch_fire}, 32'h2);

        // ---- All channels period 1: staggered fires every tick ----
        write_cfg(0, 1, 1'b0, 1'b1);
        write_cfg(2, 1, 1'b0, 1'b1);
        write_cfg(3, 1, 1'b0, 1'b1);
        chk("all_busy", {28'd0, ch_busy}, 32'hF);
        for (int k = 0; k < 2; k++) begin
            wait_tick();
            step(1);
            chk("all_t1", {28'd0, ch_fire}, 32'd0);
            for (int i = 0; i < N_CH; i++) begin
                step(1);
                chk("all_stagger", {28'd0, ch_fire}, 32'd1 << i);
            end
            step(1);
            chk("all_t6", {28'd0, ch_fire}, 32'd0);
        end

        // ---- Reset mid-SERVICE aborts the sweep ----
        wait_tick();
        step(1);
        reset = 1'b1;
        #1;
        chk("abort_fire",  {28'd0, ch_fire}, 32'd0);
        chk("abort_busy",  {28'd0, ch_busy}, 32'd0);
        chk("abort_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);
        chk("abort_pre",   {28'd0, prescale}, 32'd0);
        step(1);
        chk("abort_hold",  {28'd0, ch_fire}, 32'd0);
        reset = 1'b0;
        step(3);
        chk("abort_after", {28'd0, ch_fire | ch_busy}, 32'd0);
        wait_tick();
        step(3);
        chk("abort_tick",  {28'd0, ch_fire}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
